// File: rtl/rgb_matrix_scan.sv
// Row-scanned RGB LED matrix driver with per-channel PWM intensity and a clearable frame buffer.
// Define RGB_MATRIX_DOUBLE_BUFFER_EN to get front/back buffers that exchange at frame start.
module rgb_matrix_scan #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int SCAN_DIV = 12500,
    parameter int PWM_BITS = 2
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [3*PWM_BITS-1:0]   wr_rgb,
    input  logic                    clr,
`ifdef RGB_MATRIX_DOUBLE_BUFFER_EN
    input  logic                    swap,
    output logic                    swap_pending,
`endif
    output logic                    busy,
    output logic [$clog2(ROWS)-1:0] s,
    output logic [COLS-1:0]         OR,
    output logic [COLS-1:0]         OG,
    output logic [COLS-1:0]         OB,
    output logic                    EN,
    output logic                    frame_start
);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int COL_W     = $clog2(COLS);
    localparam int DIV_W     = $clog2(SCAN_DIV);
    localparam int PIX_W     = 3 * PWM_BITS;
    localparam int PWM_STEPS = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] LAST_STEP = PWM_BITS'(PWM_STEPS - 1);
`ifdef RGB_MATRIX_DOUBLE_BUFFER_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    scan_state_t         state;
    logic [PWM_BITS-1:0] step;
    logic [PWM_BITS-1:0] next_step;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic                frame_end;
    logic [ROW_W-1:0]    clr_row;
    logic                col_ok;
    logic                wr_ok;
    logic                front_bank;
    logic [COLS-1:0]     drv_r, drv_g, drv_b;
    logic [PIX_W-1:0]    row_pix  [COLS];
    logic [PIX_W-1:0]    bank_pix [NBUF][COLS];

    assign EN        = 1'b1;
    assign tick      = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tick && (state == DRIVE) && (step == LAST_STEP) && (s == ROW_W'(ROWS - 1));

    always_ff @(posedge CLK) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // Only a non-power-of-2 column count can produce an out-of-range column index.
    if ((1 << COL_W) == COLS) begin : g_col_pow2
        assign col_ok = 1'b1;
    end else begin : g_col_range
        assign col_ok = ({1'b0, wr_col} < (COL_W + 1)'(COLS));
    end

    assign wr_ok = wr_en && !clr && !busy && col_ok;

    always_ff @(posedge CLK) begin
        if (reset) begin
            busy    <= 1'b0;
            clr_row <= '0;
        end else if (busy) begin
            clr_row <= clr_row + 1'b1;
            if (clr_row == ROW_W'(ROWS - 1))
                busy <= 1'b0;
        end else if (clr) begin
            busy    <= 1'b1;
            clr_row <= '0;
        end
    end

    for (genvar b = 0; b < NBUF; b++) begin : g_bank
        logic [PIX_W-1:0] mem [ROWS][COLS];
        logic             is_back;

        assign is_back = (NBUF == 1) || (front_bank != (b == 1));

        always_ff @(posedge CLK) begin
            if (reset) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        mem[r][c] <= '0;
            end else if (busy && is_back) begin
                for (int c = 0; c < COLS; c++)
                    mem[clr_row][c] <= '0;
            end else if (wr_ok && is_back) begin
                mem[wr_row][wr_col] <= wr_rgb;
            end
        end

        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign bank_pix[b][c] = mem[s][c];
        end
    end

`ifdef RGB_MATRIX_DOUBLE_BUFFER_EN
    // A swap requested during a clear waits for the first frame boundary after busy drops.
    always_ff @(posedge CLK) begin
        if (reset) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (frame_end && swap_pending && !busy)
                front_bank <= ~front_bank;
            if (swap)
                swap_pending <= 1'b1;
            else if (frame_end && !busy)
                swap_pending <= 1'b0;
        end
    end
`else
    assign front_bank = 1'b0;
`endif

    // Column drive for the step about to start, taken from the displayed row.
    always_comb begin
        next_step = (state == BLANK) ? '0 : step + 1'b1;
        drv_r     = '1;
        drv_g     = '1;
        drv_b     = '1;
        for (int c = 0; c < COLS; c++) begin
            row_pix[c] = front_bank ? bank_pix[NBUF-1][c] : bank_pix[0][c];
            drv_r[c]   = !(row_pix[c][PIX_W-1 -: PWM_BITS] > next_step);
            drv_g[c]   = !(row_pix[c][2*PWM_BITS-1 -: PWM_BITS] > next_step);
            drv_b[c]   = !(row_pix[c][PWM_BITS-1:0] > next_step);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= BLANK;
            step        <= '0;
            s           <= '0;
            OR          <= '1;
            OG          <= '1;
            OB          <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                if (state == BLANK) begin
                    state <= DRIVE;
                    step  <= next_step;
                    OR    <= drv_r;
                    OG    <= drv_g;
                    OB    <= drv_b;
                end else if (step == LAST_STEP) begin
                    state       <= BLANK;
                    s           <= s + 1'b1;
                    OR          <= '1;
                    OG          <= '1;
                    OB          <= '1;
                    frame_start <= frame_end;
                end else begin
                    step <= next_step;
                    OR   <= drv_r;
                    OG   <= drv_g;
                    OB   <= drv_b;
                end
            end
        end
    end
endmodule

// File: tb/tb_rgb_matrix_scan.sv
// Directed bench for rgb_matrix_scan (8x8, SCAN_DIV=4, PWM_BITS=2: row = 16 clk, frame = 128 clk).
module tb_rgb_matrix_scan;
    localparam int ROWS = 8, COLS = 8, SCAN_DIV = 4, PWM_BITS = 2;

    logic       CLK    = 1'b0;
    logic       reset  = 1'b1;
    logic       wr_en  = 1'b0;
    logic       clr    = 1'b0;
    logic [2:0] wr_row = '0;
    logic [2:0] wr_col = '0;
    logic [5:0] wr_rgb = '0;
    logic       busy, EN, frame_start;
    logic [2:0] s;
    logic [7:0] OR, OG, OB;
`ifdef RGB_MATRIX_DOUBLE_BUFFER_EN
    logic       swap = 1'b0;
    logic       swap_pending;
`endif

    int errors = 0;
    int checks = 0;
    int k = 0;
    logic [5:0] mfront [8][8];
    logic [5:0] mback  [8][8];

    rgb_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .PWM_BITS(PWM_BITS)) dut (
        .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_rgb(wr_rgb), .clr(clr),
`ifdef RGB_MATRIX_DOUBLE_BUFFER_EN
        .swap(swap), .swap_pending(swap_pending),
`endif
        .busy(busy), .s(s), .OR(OR), .OG(OG), .OB(OB), .EN(EN), .frame_start(frame_start)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h k=%0d", tag, observed, expected, k);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
        k++;
    endtask

    // Drive one cycle of inputs, then return them to idle.
    task automatic applyStimulus(input logic we, input logic [2:0] r, input logic [2:0] c,
                                 input logic [5:0] rgb, input logic cl);
        wr_en = we; wr_row = r; wr_col = c; wr_rgb = rgb; clr = cl;
        nextCycle();
        wr_en = 1'b0; clr = 1'b0;
    endtask

    // Expected scan state from the cycle count since reset release and the displayed model.
    task automatic checkScan();
        int p, row, st;
        logic [7:0] er, eg, eb;
        p = k % 16;
        row = (k / 16) % 8;
        er = '1; eg = '1; eb = '1;
        if (p >= 4) begin
            st = (p - 4) / 4;
            for (int c = 0; c < 8; c++) begin
                if (int'(mfront[row][c][5:4]) > st) er[c] = 1'b0;
                if (int'(mfront[row][c][3:2]) > st) eg[c] = 1'b0;
                if (int'(mfront[row][c][1:0]) > st) eb[c] = 1'b0;
            end
        end
        checkOutput("s", 32'(s), 32'(row));
        checkOutput("frame_start", 32'(frame_start), ((k % 128 == 0) && (k > 0)) ? 32'd1 : 32'd0);
        checkOutput("OR", 32'(OR), 32'(er));
        checkOutput("OG", 32'(OG), 32'(eg));
        checkOutput("OB", 32'(OB), 32'(eb));
    endtask

    task automatic runScan(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            checkScan();
        end
    endtask

    task automatic syncTick();
        nextCycle();
        while (k % 4 != 0) nextCycle();
    endtask

    task automatic gotoPhase(input int target);
        for (int i = 0; i < 256 && (k % 128) != target; i++) nextCycle();
        checkOutput("phase_reached", 32'(k % 128), 32'(target));
    endtask

    task automatic clearModels();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                mfront[r][c] = '0;
                mback[r][c] = '0;
            end
    endtask

    // Make the written buffer the displayed one.
    task automatic commit();
`ifdef RGB_MATRIX_DOUBLE_BUFFER_EN
        logic [5:0] t;
        swap = 1'b1;
        nextCycle();
        swap = 1'b0;
        checkOutput("swap_pending_set", 32'(swap_pending), 32'd1);
        for (int i = 0; i < 200 && (k % 128) != 0; i++) begin
            nextCycle();
            if (k % 128 == 0) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        t = mfront[r][c];
                        mfront[r][c] = mback[r][c];
                        mback[r][c] = t;
                    end
                checkOutput("swap_pending_clr", 32'(swap_pending), 32'd0);
            end
            checkScan();
        end
`else
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mfront[r][c] = mback[r][c];
`endif
    endtask

    initial begin
        clearModels();

        // Reset and free run: first frame_start 128 clk after release, rows every 16 clk.
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b0;
        k = 0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_EN", 32'(EN), 32'd1);
        checkScan();
        runScan(300);

        // Single pixel R=3 G=1 B=0 at row 2, col 5.
        $display("[TB] single pixel write");
        applyStimulus(1'b1, 3'd2, 3'd5, 6'b11_01_00, 1'b0);
        mback[2][5] = 6'b11_01_00;
        commit();
        syncTick();
        gotoPhase(32);
        checkOutput("blank_OR", 32'(OR), 32'hFF);
        checkOutput("blank_OG", 32'(OG), 32'hFF);
        gotoPhase(36);
        checkOutput("step0_OR", 32'(OR), 32'hDF);
        checkOutput("step0_OG", 32'(OG), 32'hDF);
        checkOutput("step0_OB", 32'(OB), 32'hFF);
        gotoPhase(40);
        checkOutput("step1_OR", 32'(OR), 32'hDF);
        checkOutput("step1_OG", 32'(OG), 32'hFF);
        gotoPhase(44);
        checkOutput("step2_OR", 32'(OR), 32'hDF);
        checkOutput("step2_OG", 32'(OG), 32'hFF);
        runScan(128);

        // Fill every pixel at full level, then clear with a blocked write mid-clear.
        $display("[TB] fill and clear");
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                applyStimulus(1'b1, 3'(r), 3'(c), 6'h3F, 1'b0);
                mback[r][c] = 6'h3F;
            end
        commit();
        syncTick();
        checkScan();
        runScan(32);
        applyStimulus(1'b0, 3'd0, 3'd0, 6'h00, 1'b1);
        checkOutput("busy_c1", 32'(busy), 32'd1);
        nextCycle();
        checkOutput("busy_c2", 32'(busy), 32'd1);
        nextCycle();
        checkOutput("busy_c3", 32'(busy), 32'd1);
        applyStimulus(1'b1, 3'd0, 3'd0, 6'h3F, 1'b0);
        checkOutput("busy_c4", 32'(busy), 32'd1);
        for (int i = 5; i <= 9; i++) begin
            nextCycle();
            checkOutput("busy_tail", 32'(busy), (i <= 8) ? 32'd1 : 32'd0);
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mback[r][c] = '0;
        commit();
        syncTick();
        checkScan();
        runScan(128);

        // Reset in the middle of a clear.
        $display("[TB] reset mid-clear");
        applyStimulus(1'b1, 3'd7, 3'd3, 6'h3F, 1'b0);
        mback[7][3] = 6'h3F;
        commit();
        syncTick();
        runScan(128);
        applyStimulus(1'b0, 3'd0, 3'd0, 6'h00, 1'b1);
        repeat (3) nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        k = 0;
        clearModels();
        checkOutput("rst2_busy", 32'(busy), 32'd0);
        checkScan();
        runScan(128);

`ifdef RGB_MATRIX_DOUBLE_BUFFER_EN
        // Back-buffer write stays dark until the swap lands at the next frame_start.
        $display("[TB] double buffer swap");
        applyStimulus(1'b1, 3'd0, 3'd0, 6'b11_00_00, 1'b0);
        mback[0][0] = 6'b11_00_00;
        gotoPhase(64);
        commit();
        gotoPhase(4);
        checkOutput("db_step0_OR", 32'(OR), 32'hFE);
        gotoPhase(12);
        checkOutput("db_step2_OR", 32'(OR), 32'hFE);
        checkOutput("db_step2_OG", 32'(OG), 32'hFF);
        runScan(16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rgb_matrix_scan.md
Name: rgb_matrix_scan

Overview:
- Parametrised row-scanned RGB LED matrix driver.
- Holds a ROWS x COLS frame buffer with PWM_BITS of intensity per colour channel.
- Drives one row index plus active-low R/G/B column lines. Each row gets a blanking slot followed by PWM sub-slots.
- Sits between the game/pattern logic, which writes pixels through a single write port, and the matrix pins; it replaces the fixed 8x8 on/off scan.

Parameters:
- ROWS, 8, number of matrix rows (>=2, power of 2).
- COLS, 8, number of columns per row.
- SCAN_DIV, 12500, CLK cycles per scan tick (>=2).
- PWM_BITS, 2, intensity bits per colour; PWM_STEPS = 2^PWM_BITS - 1 drive ticks per row.

Ports:
- CLK  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  pixel write strobe, single cycle.
- wr_row  in  $clog2(ROWS)  target row.
- wr_col  in  $clog2(COLS)  target column.
- wr_rgb  in  3*PWM_BITS  pixel levels, packed {R,G,B}, each PWM_BITS wide.
- clr  in  1  clear-buffer request, single cycle.
- busy  out  1  high while a clear is in progress.
- s  out  $clog2(ROWS)  currently driven row index.
- OR  out  COLS  red column drive, active low.
- OG  out  COLS  green column drive, active low.
- OB  out  COLS  blue column drive, active low.
- EN  out  1  matrix enable; constant 1.
- frame_start  out  1  one-cycle pulse when row 0 blanking begins.

Behaviour:
- Reset values:
  - s = 0; OR/OG/OB all ones (dark); busy = 0; frame_start = 0.
  - Tick divider = 0; scan phase = BLANK; PWM step = 0.
  - All frame-buffer entries = 0.
- Tick generator:
  - Divider counts 0..SCAN_DIV-1.
  - tick asserts for one cycle when the divider equals SCAN_DIV-1, then the divider wraps to 0.
- Scan FSM, advancing only on tick:
  - BLANK: columns all ones. Lasts 1 tick, then goes to DRIVE with step = 0.
  - DRIVE: lasts PWM_STEPS ticks. On step k, a column bit is driven low iff that channel's level > k. After step PWM_STEPS-1, s increments (ROWS-1 wraps to 0) and the FSM returns to BLANK.
- Timing:
  - Row period = (PWM_STEPS+1)*SCAN_DIV clocks.
  - Frame period = ROWS * row period.
- Level mapping: level 0 = always off; level 2^PWM_BITS-1 = on for every DRIVE step.
- frame_start pulses for exactly one cycle, on the cycle the FSM enters BLANK with s = 0. It does not pulse out of reset.
- Outputs s, OR, OG and OB are registered. Column data is sampled from the buffer at each tick boundary.
- Write latency:
  - A write is stored on the cycle after wr_en.
  - It becomes visible at the next DRIVE tick of its row; a DRIVE phase already in progress picks up new data on its next step.
- Clear:
  - A clr pulse while idle sets busy on the next cycle.
  - The block then zeroes one row per cycle, for ROWS cycles, then deasserts busy.
  - clr while busy is ignored.
- Write conflicts:
  - wr_en while busy is dropped.
  - wr_en together with clr in the same cycle: clr wins and the write is dropped.
- Out-of-range wr_row/wr_col (non-power-of-2 COLS): the write is dropped.
- Scanning continues unaffected during a clear.
- Reset mid-clear or mid-scan: on the next cycle every state returns to its reset values and the buffer reads all zero.

Optional Feature:
- Macro: RGB_MATRIX_DOUBLE_BUFFER_EN.
- Defined:
  - Adds two front/back frame buffers, an input port swap (1) and an output port swap_pending (1).
  - Writes and clears target the back buffer; the scan reads the front buffer.
  - A swap pulse sets swap_pending. The buffers exchange on the cycle frame_start asserts, and swap_pending clears then.
  - A swap during busy is held pending until busy falls.
- Undefined: single buffer; writes go directly to the displayed buffer; neither port exists.

Test Plan (ROWS=8, COLS=8, SCAN_DIV=4, PWM_BITS=2 → row = 16 clk, frame = 128 clk):
1. Assert reset for 3 cycles, then release → OR=OG=OB=8'hFF, s=0, busy=0, EN=1. The first frame_start comes 128 clk after release, not before.
2. Write row 2, col 5, rgb={R=3,G=1,B=0}, no other pixels set → in row 2 DRIVE, OR=8'hDF on steps 0-2; OG=8'hDF on step 0 only and 8'hFF on steps 1-2; OB=8'hFF throughout. BLANK tick is all 8'hFF.
3. Free run for 300 clk → s steps 0..7,0 every 16 clk; frame_start pulses at 128-clk spacing, each exactly one cycle wide.
4. Fill all pixels with level 3, pulse clr, and attempt a write at clear cycle 3 → busy high exactly 8 cycles; the write is absent afterwards; all columns stay 8'hFF for a full frame.
5. Pulse clr, assert reset 4 cycles later → busy=0 on the cycle after reset; buffer all zero; s=0.
6. With RGB_MATRIX_DOUBLE_BUFFER_EN defined: write row 0, col 0, R=3, then pulse swap mid-frame → pixel stays dark until the next frame_start; swap_pending clears then; OR=8'hFE during row 0 DRIVE of that frame.
